// File: rtl/bit4_serializer.sv
// bit4_serializer: parallel-in, serial-out transmitter.
// Word load over valid/ready, one bit per beat, end-of-word flag.
module bit4_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   input  logic             sout_ready,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_rot;
   logic [CW-1:0]    cnt;
   logic             beat;
   logic             at_last;
   logic             load_acc;
   logic             first_bit;
   logic             next_bit;

   assign beat     = sout_valid && sout_ready;
   assign at_last  = (cnt == CNT_LAST);
   assign load_acc = load_valid && load_ready;

   // Rotation keeps every sreg bit live; the bit that wraps around
   // is never emitted because the word ends first.
   assign sreg_rot = MSB_FIRST ?
                     {sreg[WIDTH-2:0], sreg[WIDTH-1]} :
                     {sreg[0], sreg[WIDTH-1:1]};

   assign first_bit = MSB_FIRST ? d[WIDTH-1] : d[0];
   assign next_bit  = MSB_FIRST ? sreg_rot[WIDTH-1] : sreg_rot[0];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: leave SHIFT only on a final beat with no reload
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load_acc) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (beat && at_last && !load_acc) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: accept a word when idle or as the last bit leaves
   always_comb begin
      busy       = (state == SHIFT);
      load_ready = (state == IDLE) ||
                   ((state == SHIFT) && at_last && sout_ready);
   end

   // Datapath: load, shift on beat, drain after the final beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg       <= '0;
         cnt        <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
      end else if (load_acc) begin
         sreg       <= d;
         cnt        <= '0;
         sout       <= first_bit;
         sout_valid <= 1'b1;
         sout_last  <= 1'b0;
      end else if ((state == SHIFT) && beat) begin
         if (!at_last) begin
            sreg      <= sreg_rot;
            cnt       <= cnt + 1'b1;
            sout      <= next_bit;
            sout_last <= (cnt == CNT_PEN);
         end else begin
            sreg       <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bit4_serializer.sv
// tb_bit4_serializer: directed and random stimulus, both bit orders.
// Expected outputs come from a queue of bits still to be sent.
module tb_bit4_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] d;
   logic         load_valid;
   logic         sout_ready;

   logic lr_m, so_m, sv_m, sl_m, bz_m;
   logic lr_l, so_l, sv_l, sl_l, bz_l;

   int checks   = 0;
   int failures = 0;

   logic        qm[$];
   logic        ql[$];
   logic [15:0] got_m;
   logic [15:0] got_l;
   int          n_m;
   int          n_l;

   always #5 clk = ~clk;

   bit4_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (lr_m),
      .sout       (so_m),
      .sout_valid (sv_m),
      .sout_last  (sl_m),
      .sout_ready (sout_ready),
      .busy       (bz_m)
   );

   bit4_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (lr_l),
      .sout       (so_l),
      .sout_valid (sv_l),
      .sout_last  (sl_l),
      .sout_ready (sout_ready),
      .busy       (bz_l)
   );

   task automatic chk1(input string tag, input logic obs,
                       input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_one(input string nm, input int n,
                          input logic head, input logic sr,
                          input logic lr, input logic so,
                          input logic sv, input logic sl,
                          input logic bz);
      logic ev;
      ev = (n > 0);
      chk1({nm, ".sout"}, so, ev ? head : 1'b0);
      chk1({nm, ".sout_valid"}, sv, ev);
      chk1({nm, ".sout_last"}, sl, (n == 1));
      chk1({nm, ".busy"}, bz, ev);
      chk1({nm, ".load_ready"}, lr, (n == 0) || (n == 1 && sr));
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) qm.push_back(w[i]);
      for (int i = 0; i < W; i++) ql.push_back(w[i]);
   endtask

   task automatic clr();
      got_m = '0;
      got_l = '0;
      n_m   = 0;
      n_l   = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk1({tag, ".m.sout"}, so_m, 1'b0);
      chk1({tag, ".m.valid"}, sv_m, 1'b0);
      chk1({tag, ".m.last"}, sl_m, 1'b0);
      chk1({tag, ".m.busy"}, bz_m, 1'b0);
      chk1({tag, ".l.sout"}, so_l, 1'b0);
      chk1({tag, ".l.valid"}, sv_l, 1'b0);
      chk1({tag, ".l.last"}, sl_l, 1'b0);
      chk1({tag, ".l.busy"}, bz_l, 1'b0);
   endtask

   // One clock: drive, compare against the model, advance the model.
   task automatic step(input logic lv, input logic [W-1:0] dv,
                       input logic sr);
      logic lr;
      @(negedge clk);
      load_valid = lv;
      d          = dv;
      sout_ready = sr;
      #1;
      cmp_one("m", qm.size(), (qm.size() > 0) ? qm[0] : 1'b0,
              sr, lr_m, so_m, sv_m, sl_m, bz_m);
      cmp_one("l", ql.size(), (ql.size() > 0) ? ql[0] : 1'b0,
              sr, lr_l, so_l, sv_l, sl_l, bz_l);
      lr = (qm.size() == 0) || (qm.size() == 1 && sr);
      if (qm.size() > 0 && sr) begin
         got_m = {got_m[14:0], qm[0]};
         n_m++;
         void'(qm.pop_front());
      end
      if (ql.size() > 0 && sr) begin
         got_l = {got_l[14:0], ql[0]};
         n_l++;
         void'(ql.pop_front());
      end
      if (lv && lr) push_word(dv);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      rst        = 1'b0;
      d          = '0;
      load_valid = 1'b0;
      sout_ready = 1'b0;
      clr();
      #3;
      chk_reset("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // single word 1010, MSB first
      clr();
      step(1'b1, 4'b1010, 1'b1);
      idle(5);
      chk16("t1.bits", got_m, 16'b1010);
      chk16("t1.count", 16'(n_m), 16'd4);
      chk1("t1.idle", bz_m, 1'b0);

      // back-to-back 1010 then 0101
      clr();
      step(1'b1, 4'b1010, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 4'b0101, 1'b1);
      idle(5);
      chk16("t2.bits", got_m, 16'b1010_0101);
      chk16("t2.count", 16'(n_m), 16'd8);

      // 1100 with two stall cycles on the second bit
      clr();
      step(1'b1, 4'b1100, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk1("t3.hold", so_m, 1'b1);
      step(1'b0, '0, 1'b0);
      chk1("t3.hold2", so_m, 1'b1);
      idle(4);
      chk16("t3.bits", got_m, 16'b1100);

      // load offered while busy mid-word is ignored
      clr();
      step(1'b1, 4'b0001, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b1);
      idle(3);
      chk16("t4.bits", got_m, 16'b0001);
      chk16("t4.count", 16'(n_m), 16'd4);

      // asynchronous reset mid-word, then a fresh word
      clr();
      step(1'b1, 4'b1011, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_reset("t5.rst");
      qm.delete();
      ql.delete();
      @(negedge clk);
      rst = 1'b1;
      clr();
      step(1'b1, 4'b0110, 1'b1);
      idle(5);
      chk16("t5.bits", got_m, 16'b0110);
      chk16("t5.count", 16'(n_m), 16'd4);

      // LSB-first instance: 0001 leaves as 1,0,0,0
      clr();
      step(1'b1, 4'b0001, 1'b1);
      idle(5);
      chk16("t6.bits", got_l, 16'b1000);
      chk16("t6.count", 16'(n_l), 16'd4);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom),
              ($urandom_range(0, 3) != 0));
      end
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bit4_serializer.md
# bit4_serializer

Parallel-in, serial-out transmitter that is the companion of the 4-bit parallel register. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per accepted serial beat, with per-bit valid, downstream backpressure and an end-of-word marker. It sits between a parallel register stage and a single-wire serial sink, such as a serial-in register or a link driver.

## Interface
- WIDTH, 4: word width in bits; legal values are ≥2.
- MSB_FIRST, 1: 1 sends d[WIDTH-1] first; 0 sends d[0] first.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- d  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  upstream offers d this cycle.
- load_ready  output  1  block accepts d this cycle; combinational.
- sout  output  1  current serial bit; registered.
- sout_valid  output  1  sout holds a valid bit; registered.
- sout_last  output  1  sout is the final bit of the word; registered.
- sout_ready  input  1  downstream consumes sout on this edge.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: a word is being sent.
- Internal registers:
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, clog2(WIDTH) bits, counting 0..WIDTH-1.
- Definitions:
  - Load accept = load_valid && load_ready.
  - Beat = sout_valid && sout_ready.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && sout_ready). This allows back-to-back words with no gap.
- IDLE + load accept:
  - sreg <= d, cnt <= 0, state <= SHIFT.
  - sout_valid <= 1, sout <= first bit of d.
  - sout_last <= 0.
- SHIFT + beat with cnt < WIDTH-1:
  - shift sreg toward the output end.
  - cnt <= cnt+1.
  - sout <= next bit.
  - sout_last <= (cnt+1 == WIDTH-1).
- SHIFT + beat with cnt == WIDTH-1:
  - With load accept on the same edge: reload exactly as from IDLE and stay in SHIFT.
  - Otherwise: state <= IDLE, sout_valid <= 0, sout_last <= 0, sout <= 0.
- SHIFT with no beat (sout_ready=0): sout, sout_valid, sout_last, sreg and cnt all hold.
- load_valid while load_ready=0 is ignored. d is not sampled and no state changes.
- Bit order:
  - MSB_FIRST=1 emits d[WIDTH-1] … d[0].
  - MSB_FIRST=0 emits d[0] … d[WIDTH-1].
- busy = (state==SHIFT).

## Timing
- Reset (rst=0): takes effect immediately and asynchronously.
  - state=IDLE, sreg=0, cnt=0.
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - load_ready=1 once rst deasserts.
- Reset mid-word aborts the word. No partial bits follow after release.
- Latency: a word accepted at edge N shows its first bit on sout from edge N until the next beat.
- With sout_ready held at 1, a word occupies exactly WIDTH consecutive cycles. sout_last is high only in the WIDTH-th cycle.
- Throughput: continuous load_valid with sout_ready=1 gives one bit per cycle, with no idle cycle between words.
- sout_valid never drops within a word. It drops only after a final beat with no reload.
- sout_last is never asserted while sout_valid=0.
- Backpressure on the last bit (cnt==WIDTH-1, sout_ready=0) forces load_ready=0. A pending load_valid waits.

## Test plan
- Reset, then load d=4'b1010 (MSB_FIRST=1) with sout_ready=1:
  - sout = 1,0,1,0 on 4 consecutive cycles; sout_valid=1 throughout.
  - sout_last=1 only on the 4th cycle.
  - The cycle after: sout_valid=0 and busy=0.
- Back-to-back 4'b1010 then 4'b0101, load_valid high continuously:
  - load_ready pulses in cycle 4.
  - sout = 1,0,1,0,0,1,0,1 with no gap; sout_last on cycles 4 and 8.
- Load 4'b1100, sout_ready=0 for 2 cycles while bit 2 is on sout:
  - sout holds at 1 and cnt holds.
  - Stream resumes 0,0, total 6 cycles; sout_last on the final 0.
- load_valid=1 with d=4'b1111 while busy sending 4'b0001 (not on the last bit):
  - load_ready=0 and 4'b1111 is ignored.
  - Output remains 0,0,0,1.
- Assert rst=0 mid-word after 2 bits of 4'b1011:
  - sout, sout_valid, sout_last and busy go to 0 immediately, without waiting for a clock.
  - After release, a new load of 4'b0110 sends 0,1,1,0.
- MSB_FIRST=0, load 4'b0001: sout = 1,0,0,0, with sout_last on the 4th bit.
